// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Only the two low address bits decide word alignment, so callers pass just those.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select for a retiring instruction plus misaligned-target detection.
module pc_next
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  assign next_pc    = pc_src ? pc_target : (pc + XLEN'(INSTR_BYTES));
  assign misaligned = pc_src & ~is_word_aligned(pc_target[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time and holds it until decode retires it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = XLEN'(DEFAULT_RESET_PC),
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              pc_src,
  input  logic [XLEN-1:0]   pc_target,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              fetch_fault,
  output logic [XLEN-1:0]   fault_addr,
  output logic [31:0]       retired_count
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] fault_addr_q;
  logic [31:0]     retired_q;
  logic [15:0]     wait_count;
  logic [15:0]     wait_count_inc;
  logic            timeout_hit;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc         (pc_q),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  assign wait_count_inc = wait_count + 16'd1;
  assign timeout_hit    = (wait_count_inc == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // A response arriving on the last allowed wait cycle still counts, so rvalid is tested first.
  always_comb begin
    state_next = state;
    unique case (state)
      S_REQ:   if (imem.imem_ready) state_next = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid)  state_next = S_HOLD;
        else if (timeout_hit)  state_next = S_FAULT;
      end
      S_HOLD:  if (instr_ack) state_next = misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      fault_addr_q <= '0;
      retired_q    <= '0;
      wait_count   <= '0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem.imem_ready) wait_count <= '0;
        end
        S_WAIT: begin
          wait_count <= wait_count_inc;
          if (imem.imem_rvalid) begin
            instr_q <= imem.imem_rdata;
          end else if (timeout_hit) begin
            fault_addr_q <= pc_q;
          end
        end
        S_HOLD: begin
          if (instr_ack) begin
            retired_q <= retired_q + 32'd1;
            if (misaligned) fault_addr_q <= pc_target;
            else            pc_q         <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Request is gated by rst_n so the bus stays idle for the whole reset window.
  assign imem.imem_req  = (state == S_REQ) & rst_n;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state == S_HOLD);
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + XLEN'(INSTR_BYTES);
  assign fetch_fault    = (state == S_FAULT);
  assign fault_addr     = fault_addr_q;
  assign retired_count  = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against an instruction-level model of the fetch stage.
module tb_fetch_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] retired_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_fault;
  logic [31:0] m_fault_addr;

  fetch_unit_if #(.XLEN(32)) imem ();

  fetch_unit #(
    .XLEN           (32),
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem.master),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ack     (instr_ack),
    .pc_src        (pc_src),
    .pc_target     (pc_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_fault   (fetch_fault),
    .fault_addr    (fault_addr),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0000_0013;
    return (addr * 32'h9E37_79B9) ^ 32'h0000_0033;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req", 32'(imem.imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
    checkOutput("rst_fault_addr", fault_addr, 32'h0);
    checkOutput("rst_retired", retired_count, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    m_pc         = 32'h0;
    m_retired    = 32'd0;
    m_fault      = 1'b0;
    m_fault_addr = 32'h0;
    #1;
    checkOutput("first_req", 32'(imem.imem_req), 32'd1);
    checkOutput("first_addr", imem.imem_addr, 32'h0);
  endtask

  // One full instruction: request accept, response, hold, retire.
  task automatic applyStimulus(input int ready_dly, input int rv_dly, input int ack_dly,
                               input logic src, input logic [31:0] tgt);
    logic [31:0] word;
    word = mem_word(m_pc);
    for (int i = 0; i < ready_dly; i++) begin
      imem.imem_ready  = 1'b0;
      imem.imem_rvalid = 1'($urandom_range(0, 1));
      checkOutput("req_hold", 32'(imem.imem_req), 32'd1);
      checkOutput("addr_hold", imem.imem_addr, m_pc);
      tick();
    end
    imem.imem_rvalid = 1'b0;
    checkOutput("req", 32'(imem.imem_req), 32'd1);
    checkOutput("addr", imem.imem_addr, m_pc);
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      checkOutput("wait_req", 32'(imem.imem_req), 32'd0);
      checkOutput("wait_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = word;
    tick();
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = $urandom;
    checkOutput("valid", 32'(instr_valid), 32'd1);
    checkOutput("instr", instr, word);
    checkOutput("pc", pc, m_pc);
    checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int i = 0; i < ack_dly; i++) begin
      imem.imem_rvalid = 1'($urandom_range(0, 1));
      imem.imem_rdata  = $urandom;
      pc_src           = 1'($urandom_range(0, 1));
      pc_target        = $urandom;
      tick();
      checkOutput("hold_instr", instr, word);
      checkOutput("hold_pc", pc, m_pc);
    end
    imem.imem_rvalid = 1'b0;
    instr_ack = 1'b1;
    pc_src    = src;
    pc_target = tgt;
    tick();
    instr_ack = 1'b0;
    pc_src    = 1'b0;
    pc_target = $urandom;
    m_retired = m_retired + 32'd1;
    if (src && (tgt % 4 != 0)) begin
      m_fault      = 1'b1;
      m_fault_addr = tgt;
    end else begin
      m_pc = src ? tgt : m_pc + 32'd4;
    end
    checkOutput("retired", retired_count, m_retired);
    checkOutput("fault", 32'(fetch_fault), 32'(m_fault));
    checkOutput("next_pc", pc, m_pc);
    if (m_fault) checkOutput("fault_addr", fault_addr, m_fault_addr);
  endtask

  initial begin
    rst_n            = 1'b0;
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    instr_ack        = 1'b0;
    pc_src           = 1'b0;
    pc_target        = 32'h0;
    @(negedge clk);
    do_reset();

    // Sequential fetches 0 -> 4 -> 8, then taken branch to 0x40.
    applyStimulus(0, 0, 0, 1'b0, 32'h0);
    applyStimulus(0, 0, 1, 1'b0, 32'h0);
    applyStimulus(5, 1, 0, 1'b1, 32'h40);
    checkOutput("branch_addr", imem.imem_addr, 32'h40);

    // PC wraps from the top of the address space without faulting.
    applyStimulus(0, 0, 0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1, TIMEOUT - 1, 0, 1'b0, 32'h0);
    checkOutput("wrap_pc", pc, 32'h0);

    for (int n = 0; n < 20; n++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
    end

    // Misaligned branch target faults but still retires.
    applyStimulus(0, 0, 0, 1'b1, 32'h42);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fault_no_req", 32'(imem.imem_req), 32'd0);
      checkOutput("fault_no_valid", 32'(instr_valid), 32'd0);
      instr_ack = 1'b1;
      tick();
    end
    instr_ack = 1'b0;
    checkOutput("fault_retired_frozen", retired_count, m_retired);
    checkOutput("fault_addr_sticky", fault_addr, 32'h42);

    // Memory never answers: fault after TIMEOUT wait cycles.
    do_reset();
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checkOutput("to_pending", 32'(fetch_fault), 32'd0);
      tick();
    end
    checkOutput("to_fault", 32'(fetch_fault), 32'd1);
    checkOutput("to_fault_addr", fault_addr, 32'h0);
    checkOutput("to_req", 32'(imem.imem_req), 32'd0);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem.imem_rvalid = 1'b0;
    checkOutput("to_late_rvalid", 32'(instr_valid), 32'd0);
    checkOutput("to_still_fault", 32'(fetch_fault), 32'd1);

    // Reset while a response is outstanding at pc 0x100.
    do_reset();
    applyStimulus(0, 0, 0, 1'b1, 32'h100);
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = 32'hBAD0_0000;
      tick();
      checkOutput("stale_valid", 32'(instr_valid), 32'd0);
      checkOutput("stale_req", 32'(imem.imem_req), 32'd1);
      checkOutput("stale_addr", imem.imem_addr, 32'h0);
    end
    imem.imem_rvalid = 1'b0;
    applyStimulus(0, 2, 0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control path.
- Holds the program counter and issues word fetches to instruction memory over a req/ready + rvalid handshake.
- Presents one instruction at a time (instr, pc, pc_plus4) to the decode stage. The op/funct3/funct7b5 fields of instr feed control decoding.
- Consumes the resolved pc_src/pc_target redirect at instruction retirement. Detects misaligned targets and memory timeouts.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT_CYCLES, 255, max cycles waiting for imem_rvalid before fault (1..2^16-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch byte address (always word aligned).
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr  output  32  current instruction to decode.
- instr_valid  output  1  instr/pc valid.
- instr_ack  input  1  decode/execute retires current instruction.
- pc_src  input  1  take pc_target (branch&zero | jump), sampled on retire.
- pc_target  input  XLEN  branch/jump target.
- pc  output  XLEN  address of current instruction.
- pc_plus4  output  XLEN  pc + 4, for link writeback.
- fetch_fault  output  1  sticky fault flag.
- fault_addr  output  XLEN  offending address.
- retired_count  output  32  retired instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_REQ, instr=0, instr_valid=0, imem_req=0 while in reset.
  - fetch_fault=0, fault_addr=0, retired_count=0, timeout counter=0.
- States: S_REQ, S_WAIT, S_HOLD, S_FAULT.
- S_REQ:
  - imem_req=1, imem_addr=pc (Moore outputs).
  - First request is high in the first clock after rst_n deasserts.
  - imem_req && imem_ready -> S_WAIT, counter cleared.
  - Request and address hold stable until accepted.
- S_WAIT:
  - imem_req=0; counter increments each cycle.
  - imem_rvalid -> instr<=imem_rdata, go to S_HOLD; instr_valid=1 from the next cycle.
  - Counter reaching TIMEOUT_CYCLES without rvalid -> S_FAULT, fault_addr<=pc.
  - rvalid and timeout in the same cycle: rvalid wins.
  - imem_rvalid outside S_WAIT is ignored.
- S_HOLD:
  - instr_valid=1; instr and pc stable.
  - On instr_ack: retired_count++ (wraps at 2^32).
    - pc_src=0 -> pc<=pc+4, go to S_REQ.
    - pc_src=1 with pc_target[1:0]==0 -> pc<=pc_target, go to S_REQ.
    - pc_src=1 with pc_target[1:0]!=0 -> S_FAULT, fault_addr<=pc_target, pc unchanged. The instruction still counts as retired.
  - instr_ack outside S_HOLD is ignored.
  - pc_src/pc_target are only sampled together with a valid ack.
- S_FAULT:
  - fetch_fault=1, imem_req=0, instr_valid=0.
  - Terminal until reset.
- Throughput: minimum 3 cycles per instruction (REQ accept, WAIT with rvalid, HOLD with ack).
- Arithmetic:
  - pc+4 is modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000), no fault.
  - pc_plus4 is combinational from pc.
- Reset mid-transaction (e.g. in S_WAIT) discards the outstanding response. A late rvalid after reset lands in S_REQ and is ignored.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum (S_REQ, S_WAIT, S_HOLD, S_FAULT).
  - INSTR_BYTES=4.
  - Default RESET_PC.
  - Alignment-check function is_word_aligned.
- One sub-module, pc_next: combinational next-PC select and misalign detect.
  - Inputs: pc, pc_src, pc_target.
  - Outputs: next_pc, misaligned.
- FSM, timeout counter and registers stay in fetch_unit.

Test Plan:
- Reset release, imem_ready=1, rvalid 1 cycle after accept with rdata=32'h0000_0013:
  - imem_req on the first post-reset cycle with imem_addr=0.
  - instr_valid with instr=0x13, pc=0, pc_plus4=4.
  - ack -> next imem_addr=4; retired_count=1.
- Taken branch: ack with pc_src=1, pc_target=0x40 at pc=8 -> next imem_addr=0x40, pc=0x40.
- imem_ready low 5 cycles -> imem_req and imem_addr=pc stable for all 5 cycles; state advances only on ready.
- TIMEOUT_CYCLES=4, no rvalid -> fetch_fault=1 after 4 WAIT cycles, fault_addr=pc, imem_req stays 0, later rvalid ignored.
- Ack with pc_src=1, pc_target=0x42 -> fetch_fault=1, fault_addr=0x42, retired_count increments, no new request.
- rst_n asserted in S_WAIT with pc=0x100 -> pc=RESET_PC, instr_valid=0. A stale rvalid after release does not produce instr_valid before a new request is accepted.
